// File: rtl/hash_seq_pkg.sv
// hash_seq_pkg: shared states, error codes and block geometry for the hash job sequencer.
package hash_seq_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CFG, S_DATA, S_DIGEST, S_DONE, S_ERR} state_t;
  localparam logic [1:0] ERR_NONE         = 2'd0;
  localparam logic [1:0] ERR_EARLY_LAST   = 2'd1;
  localparam logic [1:0] ERR_MISSING_LAST = 2'd2;
  localparam logic [1:0] ERR_SIZE_TIMEOUT = 2'd3;
  localparam int BLK_SHIFT = 9;
endpackage

// File: rtl/hash_seq_timeout.sv
// hash_seq_timeout: idle-handshake watchdog, used only when HASH_SEQ_TIMEOUT_EN is defined.
module hash_seq_timeout #(
  parameter int CYCLES = 65535
) (
  input  logic HCLK,
  input  logic HRESET,
  input  logic i_run,
  input  logic i_kick,
  output logic o_expired
);
  localparam int W = $clog2(CYCLES + 1);
  logic [W-1:0] r_cnt;
  assign o_expired = i_run & ~i_kick & (r_cnt == W'(CYCLES - 1));
  always_ff @(posedge HCLK or posedge HRESET)
    if (HRESET) r_cnt <= '0;
    else r_cnt <= (!i_run || i_kick || o_expired) ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/hash_job_sequencer.sv
// hash_job_sequencer: per-message job controller for the SHA-256 engine.
module hash_job_sequencer
  import hash_seq_pkg::*;
#(
  parameter int SIZEWIDTH      = 64,
  parameter int CNTWIDTH       = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic [SIZEWIDTH-1:0] job_size,
  input  logic [1:0]           job_scheme,
  input  logic                 job_valid,
  output logic                 job_ready,
  output logic [SIZEWIDTH-1:0] cfg_size,
  output logic [1:0]           cfg_scheme,
  output logic                 cfg_last,
  output logic                 cfg_valid,
  input  logic                 cfg_ready,
  input  logic                 in_pkt_valid,
  input  logic                 in_pkt_ready,
  input  logic                 in_pkt_last,
  input  logic                 out_pkt_valid,
  input  logic                 out_pkt_ready,
  input  logic                 out_pkt_last,
  output logic                 in_req_en,
  output logic                 out_req_en,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [1:0]           err_code,
  input  logic                 err_clear,
  output logic [CNTWIDTH-1:0]  pkt_count
);
  localparam logic [SIZEWIDTH:0] MAX_EXP = (SIZEWIDTH + 1)'({CNTWIDTH{1'b1}});
  state_t                r_state, w_next;
  logic [SIZEWIDTH-1:0]  r_size;
  logic [1:0]            r_scheme, r_code, w_code;
  logic [CNTWIDTH-1:0]   r_exp, r_cnt, w_n;
  logic [SIZEWIDTH:0]    w_exp;
  logic                  w_bad, w_in_hs, w_out_hs, w_accept, w_kick, w_to;
  assign w_exp    = ({1'b0, job_size} + (SIZEWIDTH + 1)'(511)) >> BLK_SHIFT;
  assign w_bad    = (job_size == '0) || (w_exp > MAX_EXP);
  assign w_in_hs  = in_pkt_valid & in_pkt_ready;
  assign w_out_hs = out_pkt_valid & out_pkt_ready;
  assign w_accept = (r_state == S_IDLE) & job_valid;
  assign w_n      = r_cnt + 1'b1;
  assign w_kick   = (r_state == S_CFG && cfg_ready) || (r_state == S_DATA && w_in_hs) ||
                    (r_state == S_DIGEST && w_out_hs);
`ifdef HASH_SEQ_TIMEOUT_EN
  hash_seq_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .i_run     (busy),
    .i_kick    (w_kick),
    .o_expired (w_to)
  );
`else
  assign w_to = 1'b0 & w_kick;
`endif
  always_comb begin
    w_next = r_state;
    w_code = r_code;
    case (r_state)
      S_IDLE: if (job_valid) begin
        w_next = w_bad ? S_ERR : S_CFG;
        w_code = w_bad ? ERR_SIZE_TIMEOUT : ERR_NONE;
      end
      S_CFG: if (cfg_ready) w_next = S_DATA;
      S_DATA: if (w_in_hs && in_pkt_last) begin
        w_next = (w_n == r_exp) ? S_DIGEST : S_ERR;
        w_code = (w_n == r_exp) ? r_code : ERR_EARLY_LAST;
      end else if (w_in_hs && w_n == r_exp) begin
        w_next = S_ERR;
        w_code = ERR_MISSING_LAST;
      end
      S_DIGEST: if (w_out_hs && out_pkt_last) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      S_ERR: if (err_clear) begin
        w_next = S_IDLE;
        w_code = ERR_NONE;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_to) begin
      w_next = S_ERR;
      w_code = ERR_SIZE_TIMEOUT;
    end
  end
  always_ff @(posedge HCLK or posedge HRESET)
    if (HRESET) begin
      r_state  <= S_IDLE;
      r_code   <= ERR_NONE;
      r_size   <= '0;
      r_scheme <= '0;
      r_exp    <= '0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_next;
      r_code  <= w_code;
      if (w_accept) begin
        r_size   <= job_size;
        r_scheme <= job_scheme;
        r_exp    <= w_exp[CNTWIDTH-1:0];
        r_cnt    <= '0;
      end else if (r_state == S_DATA && w_in_hs) r_cnt <= w_n;
    end
  assign job_ready  = r_state == S_IDLE;
  assign cfg_valid  = r_state == S_CFG;
  assign cfg_last   = r_state == S_CFG;
  assign cfg_size   = r_size;
  assign cfg_scheme = r_scheme;
  assign in_req_en  = r_state == S_DATA;
  assign out_req_en = r_state == S_DIGEST;
  assign busy       = (r_state == S_CFG) || (r_state == S_DATA) || (r_state == S_DIGEST);
  assign done       = r_state == S_DONE;
  assign err        = r_state == S_ERR;
  assign err_code   = r_code;
  assign pkt_count  = r_cnt;
endmodule

// File: tb/tb_hash_job_sequencer.sv
// tb_hash_job_sequencer: table-driven job vectors plus hand-written latency, stall, reset and timeout sequences.
module tb_hash_job_sequencer;
  logic        HCLK = 1'b0, HRESET = 1'b1;
  logic [63:0] job_size = '0;
  logic [1:0]  job_scheme = '0;
  logic        job_valid = 1'b0, job_ready;
  logic [63:0] cfg_size;
  logic [1:0]  cfg_scheme, err_code;
  logic        cfg_last, cfg_valid, cfg_ready = 1'b0;
  logic        in_pkt_valid = 1'b0, in_pkt_ready = 1'b0, in_pkt_last = 1'b0;
  logic        out_pkt_valid = 1'b0, out_pkt_ready = 1'b0, out_pkt_last = 1'b0;
  logic        in_req_en, out_req_en, busy, done, err, err_clear = 1'b0;
  logic [15:0] pkt_count;
  int checks = 0, errors = 0;
`ifdef HASH_SEQ_TIMEOUT_EN
  localparam int CFG_HOLD = 6;
`else
  localparam int CFG_HOLD = 10;
`endif
  hash_job_sequencer #(.TIMEOUT_CYCLES(8)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .job_size(job_size), .job_scheme(job_scheme),
    .job_valid(job_valid), .job_ready(job_ready), .cfg_size(cfg_size), .cfg_scheme(cfg_scheme),
    .cfg_last(cfg_last), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .in_pkt_valid(in_pkt_valid), .in_pkt_ready(in_pkt_ready), .in_pkt_last(in_pkt_last),
    .out_pkt_valid(out_pkt_valid), .out_pkt_ready(out_pkt_ready), .out_pkt_last(out_pkt_last),
    .in_req_en(in_req_en), .out_req_en(out_req_en), .busy(busy), .done(done), .err(err),
    .err_code(err_code), .err_clear(err_clear), .pkt_count(pkt_count)
  );
  always #5 HCLK = ~HCLK;
  typedef struct {
    logic [63:0] size;
    logic [1:0]  scheme;
    int          npk;
    int          last_at;
    logic        bad;
    logic        exp_err;
    logic [1:0]  code;
    logic [15:0] cnt;
  } vec_t;
  vec_t vecs[10];
  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, act, exp);
    end
  endtask
  task automatic chk_reset_vals(input string n);
    chk({n, "_flags"}, {job_ready, cfg_valid, cfg_last, in_req_en, out_req_en, busy, done, err}, 8'b1000_0000);
    chk({n, "_cfg_size"}, cfg_size, 0);
    chk({n, "_cfg_scheme"}, cfg_scheme, 0);
    chk({n, "_err_code"}, err_code, 0);
    chk({n, "_pkt_count"}, pkt_count, 0);
  endtask
  task automatic run_vec(input vec_t v, input int idx);
    int p;
    job_size = v.size; job_scheme = v.scheme; job_valid = 1'b1;
    tick;
    job_valid = 1'b0;
    if (v.bad) begin
      chk($sformatf("v%0d_no_cfg_valid", idx), cfg_valid, 0);
    end else begin
      chk($sformatf("v%0d_cfg_valid", idx), cfg_valid, 1);
      chk($sformatf("v%0d_cfg_size", idx), cfg_size, v.size);
      chk($sformatf("v%0d_cfg_scheme", idx), cfg_scheme, v.scheme);
      cfg_ready = 1'b1;
      tick;
      cfg_ready = 1'b0;
      chk($sformatf("v%0d_in_req_en_on", idx), in_req_en, 1);
      p = 0;
      in_pkt_valid = 1'b1; in_pkt_ready = 1'b1;
      while (in_req_en && p < v.npk) begin
        p++;
        in_pkt_last = (p == v.last_at);
        tick;
      end
      in_pkt_valid = 1'b0; in_pkt_ready = 1'b0; in_pkt_last = 1'b0;
      chk($sformatf("v%0d_in_req_en_off", idx), in_req_en, 0);
      if (!v.exp_err) begin
        chk($sformatf("v%0d_out_req_en", idx), out_req_en, 1);
        out_pkt_valid = 1'b1; out_pkt_ready = 1'b1; out_pkt_last = 1'b1;
        tick;
        out_pkt_valid = 1'b0; out_pkt_ready = 1'b0; out_pkt_last = 1'b0;
        chk($sformatf("v%0d_done", idx), done, 1);
        tick;
        chk($sformatf("v%0d_idle_after_done", idx), {job_ready, done}, 2'b10);
      end
      chk($sformatf("v%0d_pkt_count", idx), pkt_count, v.cnt);
    end
    chk($sformatf("v%0d_err", idx), err, v.exp_err);
    chk($sformatf("v%0d_err_code", idx), err_code, v.code);
    if (v.exp_err) begin
      err_clear = 1'b1;
      tick;
      err_clear = 1'b0;
      chk($sformatf("v%0d_cleared", idx), {job_ready, err, err_code}, 4'b1000);
    end
  endtask
  initial begin
    int n;
    vecs[0] = '{64'd512, 2'd0, 1, 1, 1'b0, 1'b0, 2'd0, 16'd1};
    vecs[1] = '{64'd1500, 2'd1, 3, 3, 1'b0, 1'b0, 2'd0, 16'd3};
    vecs[2] = '{64'd1500, 2'd2, 3, 2, 1'b0, 1'b1, 2'd1, 16'd2};
    vecs[3] = '{64'd1024, 2'd3, 3, 0, 1'b0, 1'b1, 2'd2, 16'd2};
    vecs[4] = '{64'd0, 2'd0, 0, 0, 1'b1, 1'b1, 2'd3, 16'd0};
    vecs[5] = '{64'd1, 2'd1, 1, 1, 1'b0, 1'b0, 2'd0, 16'd1};
    vecs[6] = '{64'd513, 2'd2, 2, 2, 1'b0, 1'b0, 2'd0, 16'd2};
    vecs[7] = '{64'd33553920, 2'd1, 1, 1, 1'b0, 1'b1, 2'd1, 16'd1};
    vecs[8] = '{64'd33553921, 2'd0, 0, 0, 1'b1, 1'b1, 2'd3, 16'd0};
    vecs[9] = '{64'hFFFF_FFFF_FFFF_FFFF, 2'd3, 0, 0, 1'b1, 1'b1, 2'd3, 16'd0};
    #1;
    chk_reset_vals("reset");
    tick; tick;
    HRESET = 1'b0;
    tick;
    chk_reset_vals("post_reset");
    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);
    in_pkt_valid = 1'b1; in_pkt_ready = 1'b1; in_pkt_last = 1'b1;
    out_pkt_valid = 1'b1; out_pkt_ready = 1'b1; out_pkt_last = 1'b1;
    job_size = 64'd512; job_valid = 1'b1;
    tick;
    job_valid = 1'b0;
    cfg_ready = 1'b1;
    n = 1;
    while (!done && n < 20) begin tick; n++; end
    chk("min_latency_edges", n, 4);
    chk("min_pkt_count", pkt_count, 1);
    chk("min_cfg_size", cfg_size, 512);
    chk("min_err", err, 0);
    tick;
    chk("min_ready_after_done", {job_ready, done}, 2'b10);
    in_pkt_valid = 1'b0; in_pkt_ready = 1'b0; in_pkt_last = 1'b0;
    out_pkt_valid = 1'b0; out_pkt_ready = 1'b0; out_pkt_last = 1'b0;
    cfg_ready = 1'b0;
    job_size = 64'd1500; job_scheme = 2'd1; job_valid = 1'b1;
    tick;
    job_valid = 1'b0; cfg_ready = 1'b1;
    tick;
    cfg_ready = 1'b0; in_pkt_valid = 1'b1; in_pkt_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_pkt_last = (i == 3);
      tick;
    end
    in_pkt_valid = 1'b0; in_pkt_ready = 1'b0; in_pkt_last = 1'b0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (out_req_en !== 1'b1 || done !== 1'b0) n++;
      tick;
    end
    chk("stall_out_req_en_held", n, 0);
    out_pkt_valid = 1'b1; out_pkt_ready = 1'b1; out_pkt_last = 1'b1;
    chk("stall_out_req_en_before_hs", out_req_en, 1);
    tick;
    out_pkt_valid = 1'b0; out_pkt_ready = 1'b0; out_pkt_last = 1'b0;
    chk("stall_done", {done, out_req_en}, 2'b10);
    tick;
    chk("stall_done_once", {done, job_ready}, 2'b01);
    job_size = 64'd0; job_valid = 1'b1;
    tick;
    chk("size0_err", {err, err_code, cfg_valid}, 4'b1110);
    job_size = 64'd1500; job_scheme = 2'd2; err_clear = 1'b1;
    tick;
    err_clear = 1'b0;
    chk("clear_no_accept", {job_ready, cfg_valid, err}, 3'b100);
    tick;
    job_valid = 1'b0;
    chk("accept_after_clear", cfg_valid, 1);
    n = 0;
    for (int i = 0; i < CFG_HOLD; i++) begin
      if (cfg_valid !== 1'b1 || cfg_last !== 1'b1 || cfg_size !== 64'd1500 || cfg_scheme !== 2'd2) n++;
      tick;
    end
    chk("cfg_hold_stable", n, 0);
    chk("cfg_hold_still_valid", {cfg_valid, in_req_en}, 2'b10);
    cfg_ready = 1'b1;
    tick;
    cfg_ready = 1'b0; in_pkt_valid = 1'b1; in_pkt_ready = 1'b1;
    tick;
    in_pkt_valid = 1'b0; in_pkt_ready = 1'b0;
    chk("mid_job_data", {in_req_en, pkt_count}, {1'b1, 16'd1});
    #2 HRESET = 1'b1;
    #1;
    chk_reset_vals("abort");
    tick;
    HRESET = 1'b0;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      if (done !== 1'b0 || err !== 1'b0) n++;
    end
    chk("abort_no_done_err", n, 0);
    job_size = 64'd1500; job_valid = 1'b1;
    tick;
    job_valid = 1'b0; cfg_ready = 1'b1;
    tick;
    cfg_ready = 1'b0;
    for (int i = 0; i < 7; i++) tick;
    chk("idle7_still_data", {in_req_en, err}, 2'b10);
    tick;
`ifdef HASH_SEQ_TIMEOUT_EN
    chk("timeout_err", {err, err_code, in_req_en}, 4'b1110);
`else
    for (int i = 0; i < 12; i++) tick;
    chk("no_timeout_data", {in_req_en, err, err_code}, 4'b1000);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
endmodule
